// File: rtl/i2c_slave_adapter_if.sv
// Bus/handshake bundle between the serial slave and its surroundings.
//   SCL_i2c  : bus clock from the I2C master
//   rx_word  : last received 24-bit write word
//   rx_valid : 1-cycle pulse, rx_word updated
//   rx_ready : core can accept a byte
//   tx_word  : word returned on a read pack
//   tx_req   : 1-cycle pulse on read-header accept
//   busy     : high from START to STOP
//   err      : 1-cycle pulse on framing error
//   sda_oe   : slave is driving SDA_i2c
// The slave modport is the adapter; the master modport is the I2C master plus core side.
interface i2c_slave_adapter_if;
    logic        SCL_i2c;
    logic [23:0] rx_word;
    logic        rx_valid;
    logic        rx_ready;
    logic [23:0] tx_word;
    logic        tx_req;
    logic        busy;
    logic        err;
    logic        sda_oe;

    modport slave (
        input  SCL_i2c, rx_ready, tx_word,
        output rx_word, rx_valid, tx_req, busy, err, sda_oe
    );

    modport master (
        output SCL_i2c, rx_ready, tx_word,
        input  rx_word, rx_valid, tx_req, busy, err, sda_oe
    );
endinterface

// File: rtl/i2c_slave_adapter.sv
// Serial-side slave of the adapter. Oversamples SCL/SDA on clk and decodes
// packs of one header byte {addr[6:0], R/W} followed by three data bytes.
// Write packs assemble one 24-bit word; read packs serialise a latched word.
// Ports:
//   clk      : system clock, >= 8x SCL
//   reset    : synchronous, active-high
//   SDA_i2c  : bus data, driven only while sda_oe=1
//   bus      : i2c_slave_adapter_if.slave (SCL, rx/tx handshake, status)
module i2c_slave_adapter #(
    parameter logic [6:0]  OWN_ADDR     = 7'h45,
    parameter int unsigned SCL_IDLE_CYC = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    inout  wire                       SDA_i2c,
    i2c_slave_adapter_if.slave        bus
);
    typedef enum logic [2:0] {
        IDLE, HDR, HDR_ACK, WR_BIT, WR_ACK, RD_BIT, RD_ACK, WAIT_STOP
    } state_t;

    localparam int unsigned CW     = $clog2(SCL_IDLE_CYC + 1);
    localparam logic [CW-1:0] HI_MAX = CW'(SCL_IDLE_CYC);

    // synchronisers and edge detection
    logic [1:0]    scl_sync, sda_sync;
    logic          scl_d, sda_d;
    logic          scl_s, sda_s;
    logic [CW-1:0] scl_hi_cnt;

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync   <= '1;
            sda_sync   <= '1;
            scl_d      <= 1'b1;
            sda_d      <= 1'b1;
            scl_hi_cnt <= '0;
        end else begin
            scl_sync <= {scl_sync[0], bus.SCL_i2c};
            sda_sync <= {sda_sync[0], SDA_i2c};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            if (!scl_s)
                scl_hi_cnt <= '0;
            else if (scl_hi_cnt != HI_MAX)
                scl_hi_cnt <= scl_hi_cnt + 1'b1;
        end
    end

    logic scl_rise, scl_fall, sda_rise, sda_fall, scl_long;
    logic stop_det, start_idle, start_long;

    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign sda_rise   = sda_s & ~sda_d;
    assign sda_fall   = ~sda_s & sda_d;
    // Data changes right after an SCL rise, so an SDA edge only counts as a
    // bus condition once SCL has been high for the full idle time.
    assign scl_long   = scl_s && (scl_hi_cnt == HI_MAX);
    assign stop_det   = sda_rise && scl_long;
    assign start_idle = sda_fall && scl_s;
    assign start_long = sda_fall && scl_long;

    // FSM state and datapath registers
    state_t      state, state_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [7:0]  shreg, shreg_n, shin, tx_byte;
    logic [23:0] rx_buf, rx_buf_n, tx_buf, tx_buf_n;
    logic        stored, stored_n, last, last_n, is_wr, is_wr_n, armed, armed_n;
    logic        sda_oe, oe_n, sda_out, out_n, valid_pend, pend_n;
    logic        rx_valid, rx_valid_n, tx_req, tx_req_n, err, err_n, busy;
    logic [23:0] rx_word, rx_word_n;
    logic        mid_byte;

    assign mid_byte = ((state == HDR) || (state == WR_BIT) || (state == RD_BIT))
                      && (bit_cnt != 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd7;
            byte_cnt   <= '0;
            shreg      <= '0;
            rx_buf     <= '0;
            tx_buf     <= '0;
            stored     <= 1'b0;
            last       <= 1'b0;
            is_wr      <= 1'b0;
            armed      <= 1'b0;
            sda_oe     <= 1'b0;
            sda_out    <= 1'b0;
            valid_pend <= 1'b0;
            rx_valid   <= 1'b0;
            rx_word    <= '0;
            tx_req     <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            byte_cnt   <= byte_cnt_n;
            shreg      <= shreg_n;
            rx_buf     <= rx_buf_n;
            tx_buf     <= tx_buf_n;
            stored     <= stored_n;
            last       <= last_n;
            is_wr      <= is_wr_n;
            armed      <= armed_n;
            sda_oe     <= oe_n;
            sda_out    <= out_n;
            valid_pend <= pend_n;
            rx_valid   <= rx_valid_n;
            rx_word    <= rx_word_n;
            tx_req     <= tx_req_n;
            err        <= err_n;
            busy       <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        shreg_n    = shreg;
        rx_buf_n   = rx_buf;
        tx_buf_n   = tx_buf;
        stored_n   = stored;
        last_n     = last;
        is_wr_n    = is_wr;
        armed_n    = armed;
        oe_n       = sda_oe;
        out_n      = sda_out;
        pend_n     = 1'b0;
        rx_valid_n = 1'b0;
        rx_word_n  = rx_word;
        tx_req_n   = 1'b0;
        err_n      = 1'b0;
        shin       = {shreg[6:0], sda_s};

        case (byte_cnt)
            2'd0:    tx_byte = tx_buf[23:16];
            2'd1:    tx_byte = tx_buf[15:8];
            default: tx_byte = tx_buf[7:0];
        endcase

        if (valid_pend) begin
            rx_valid_n = 1'b1;
            rx_word_n  = rx_buf;
        end

        if (stop_det) begin
            err_n      = mid_byte;
            state_n    = IDLE;
            oe_n       = 1'b0;
            out_n      = 1'b0;
            bit_cnt_n  = 3'd7;
            byte_cnt_n = '0;
            stored_n   = 1'b0;
            last_n     = 1'b0;
            armed_n    = 1'b0;
        end else if ((state != IDLE) && start_long) begin
            err_n   = mid_byte;
            state_n = WAIT_STOP;
            oe_n    = 1'b0;
            last_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_idle) begin
                        state_n    = HDR;
                        bit_cnt_n  = 3'd7;
                        byte_cnt_n = '0;
                        rx_buf_n   = '0;
                        stored_n   = 1'b0;
                        last_n     = 1'b0;
                        armed_n    = 1'b0;
                    end
                end
                HDR: begin
                    // The SCL fall that completes START carries no data; only
                    // falls that follow a rise inside the pack are sampled.
                    if (scl_rise) begin
                        armed_n = 1'b1;
                    end else if (scl_fall && armed) begin
                        shreg_n = shin;
                        if (bit_cnt == 3'd0) begin
                            bit_cnt_n = 3'd7;
                            if (shin[7:1] == OWN_ADDR) begin
                                state_n = HDR_ACK;
                                is_wr_n = ~shin[0];
                                if (shin[0]) begin
                                    tx_req_n = 1'b1;
                                    tx_buf_n = bus.tx_word;
                                end
                            end else begin
                                state_n = WAIT_STOP;
                                is_wr_n = 1'b0;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt - 3'd1;
                        end
                    end
                end
                HDR_ACK: begin
                    // sda_oe tells apart the rise that starts the ACK from the one ending it
                    if (scl_rise) begin
                        if (!sda_oe) begin
                            oe_n  = 1'b1;
                            out_n = 1'b1;
                        end else if (is_wr) begin
                            oe_n    = 1'b0;
                            state_n = WR_BIT;
                        end else begin
                            oe_n    = 1'b1;
                            out_n   = tx_byte[bit_cnt];
                            state_n = RD_BIT;
                        end
                    end
                end
                WR_BIT: begin
                    if (scl_fall) begin
                        shreg_n = shin;
                        if (bit_cnt == 3'd0) begin
                            bit_cnt_n = 3'd7;
                            state_n   = WR_ACK;
                            stored_n  = bus.rx_ready;
                            if (bus.rx_ready) begin
                                case (byte_cnt)
                                    2'd0:    rx_buf_n[23:16] = shin;
                                    2'd1:    rx_buf_n[15:8]  = shin;
                                    default: rx_buf_n[7:0]   = shin;
                                endcase
                                if (byte_cnt == 2'd2)
                                    last_n = 1'b1;
                                else
                                    byte_cnt_n = byte_cnt + 2'd1;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt - 3'd1;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_rise) begin
                        if (!sda_oe) begin
                            oe_n   = 1'b1;
                            out_n  = stored;
                            pend_n = stored && last;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = last ? WAIT_STOP : WR_BIT;
                        end
                    end
                end
                RD_BIT: begin
                    if (scl_rise) begin
                        oe_n  = 1'b1;
                        out_n = tx_byte[bit_cnt];
                    end else if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            bit_cnt_n = 3'd7;
                            state_n   = RD_ACK;
                        end else begin
                            bit_cnt_n = bit_cnt - 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        oe_n = 1'b0;
                    end else if (scl_fall) begin
                        if (sda_s && (byte_cnt == 2'd2)) begin
                            state_n = WAIT_STOP;
                        end else begin
                            if (sda_s)
                                byte_cnt_n = byte_cnt + 2'd1;
                            state_n = RD_BIT;
                        end
                    end
                end
                WAIT_STOP: begin
                    oe_n = 1'b0;
                    // last doubles as a one-shot flag for the surplus-byte error
                    if (scl_fall && is_wr && last) begin
                        err_n  = 1'b1;
                        last_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign SDA_i2c      = sda_oe ? sda_out : 1'bz;
    assign bus.sda_oe   = sda_oe;
    assign bus.rx_word  = rx_word;
    assign bus.rx_valid = rx_valid;
    assign bus.tx_req   = tx_req;
    assign bus.busy     = busy;
    assign bus.err      = err;
endmodule
